rs_int_issue_select: RTL and testbench

//  Integer reservation-station controller for LINE_NUM RS lines. Downstream of dispatch and upstream of the integer ALU.

---
 rtl/rs_pkg.sv | 15 +
 rtl/rs_int_issue_select_if.sv | 34 +++
 rtl/rs_age_select.sv | 41 ++++
 rtl/rs_int_issue_select.sv | 97 +++++++++
 tb/tb_rs_int_issue_select.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rs_pkg.sv
// Shared reservation-station definitions.
// Line state encoding seen by the RS controller.
package rs_pkg;

    localparam int RS_STATE_W = 3;

    typedef enum logic [RS_STATE_W-1:0] {
        RS_NONE   = 3'd0,
        RS_WRITE  = 3'd1,
        RS_READY  = 3'd2,
        RS_WAIT   = 3'd3,
        RS_COMMIT = 3'd4
    } rs_state_e;

endpackage

// File: rtl/rs_int_issue_select_if.sv
// Issue packet bus from the integer RS to the ALU.
// valid/ready handshake with registered packet fields.
interface rs_int_issue_select_if #(
    parameter int ROB_ADDR_W = 5,
    parameter int OPGEN_W    = 8,
    parameter int DATA_W     = 32
);

    logic                  valid;
    logic                  ready;
    logic [ROB_ADDR_W-1:0] rob_addr;
    logic [OPGEN_W-1:0]    opgen;
    logic [DATA_W-1:0]     opnd1;
    logic [DATA_W-1:0]     opnd2;

    modport master (
        output valid,
        output rob_addr,
        output opgen,
        output opnd1,
        output opnd2,
        input  ready
    );

    modport slave (
        input  valid,
        input  rob_addr,
        input  opgen,
        input  opnd1,
        input  opnd2,
        output ready
    );

endinterface

// File: rtl/rs_age_select.sv
// Oldest-eligible picker: argmin of ROB age relative to rob_head.
// Ties resolve to the lowest line index.
module rs_age_select #(
    parameter int LINE_NUM   = 4,
    parameter int ROB_ADDR_W = 5,
    parameter int IDX_W      = 2
) (
    input  logic [LINE_NUM-1:0]            eligible,
    input  logic [LINE_NUM*ROB_ADDR_W-1:0] rob_addr,
    input  logic [ROB_ADDR_W-1:0]          rob_head,
    output logic [LINE_NUM-1:0]            onehot,
    output logic [IDX_W-1:0]               idx,
    output logic                           any
);

    logic [ROB_ADDR_W-1:0] age [LINE_NUM];
    logic [ROB_ADDR_W-1:0] best;

    // Wrap-around subtraction gives distance from the ROB head.
    always_comb begin
        for (int i = 0; i < LINE_NUM; i++) begin
            age[i] = rob_addr[i*ROB_ADDR_W +: ROB_ADDR_W] - rob_head;
        end
    end

    always_comb begin
        any  = 1'b0;
        idx  = '0;
        best = '0;
        for (int i = 0; i < LINE_NUM; i++) begin
            if (eligible[i] && (!any || age[i] < best)) begin
                any  = 1'b1;
                idx  = IDX_W'(i);
                best = age[i];
            end
        end
        onehot = '0;
        if (any) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/rs_int_issue_select.sv
// Integer RS controller: line allocation, oldest-ready issue
// select and registered issue packet toward the ALU.
module rs_int_issue_select
    import rs_pkg::*;
#(
    parameter int LINE_NUM   = 4,
    parameter int ROB_ADDR_W = 5,
    parameter int OPGEN_W    = 8,
    parameter int DATA_W     = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic [ROB_ADDR_W-1:0]            rob_head,
    input  logic                             alloc_valid,
    output logic                             alloc_ready,
    output logic [LINE_NUM-1:0]              line_write_en,
    input  logic [LINE_NUM*RS_STATE_W-1:0]   line_state,
    input  logic [LINE_NUM*ROB_ADDR_W-1:0]   line_rob_addr,
    input  logic [LINE_NUM*OPGEN_W-1:0]      line_opgen,
    input  logic [LINE_NUM*DATA_W-1:0]       line_opnd1,
    input  logic [LINE_NUM*DATA_W-1:0]       line_opnd2,
    output logic [LINE_NUM-1:0]              line_issue_en,
    rs_int_issue_select_if.master            iss
);

    localparam int IDX_W = $clog2(LINE_NUM);
    localparam int SW    = RS_STATE_W;

    logic [LINE_NUM-1:0] free;
    logic [LINE_NUM-1:0] elig;
    logic [LINE_NUM-1:0] issued_mask;
    logic [LINE_NUM-1:0] win_oh;
    logic [IDX_W-1:0]    win_idx;
    logic                win_any;
    logic                cap;

    always_comb begin
        for (int i = 0; i < LINE_NUM; i++) begin
            free[i] = line_state[i*SW +: SW] == RS_NONE;
            elig[i] = line_state[i*SW +: SW] == RS_READY
                      && !issued_mask[i];
        end
    end

    assign alloc_ready = |free;

    // Isolate the lowest set bit of the free vector.
    assign line_write_en =
        (alloc_valid && alloc_ready && !flush && !rst)
        ? (free & (~free + LINE_NUM'(1))) : '0;

    rs_age_select #(
        .LINE_NUM   (LINE_NUM),
        .ROB_ADDR_W (ROB_ADDR_W),
        .IDX_W      (IDX_W)
    ) u_age (
        .eligible (elig),
        .rob_addr (line_rob_addr),
        .rob_head (rob_head),
        .onehot   (win_oh),
        .idx      (win_idx),
        .any      (win_any)
    );

    assign cap = win_any && (!iss.valid || iss.ready)
                 && !flush && !rst;

    assign line_issue_en = cap ? win_oh : '0;

    // Mask covers the one cycle before the line leaves READY.
    always_ff @(posedge clk) begin
        if (rst) begin
            iss.valid    <= 1'b0;
            iss.rob_addr <= '0;
            iss.opgen    <= '0;
            iss.opnd1    <= '0;
            iss.opnd2    <= '0;
            issued_mask  <= '0;
        end else if (flush) begin
            iss.valid   <= 1'b0;
            issued_mask <= '0;
        end else begin
            issued_mask <= line_issue_en;
            if (cap) begin
                iss.valid    <= 1'b1;
                iss.rob_addr <= line_rob_addr[win_idx*ROB_ADDR_W +: ROB_ADDR_W];
                iss.opgen    <= line_opgen[win_idx*OPGEN_W +: OPGEN_W];
                iss.opnd1    <= line_opnd1[win_idx*DATA_W +: DATA_W];
                iss.opnd2    <= line_opnd2[win_idx*DATA_W +: DATA_W];
            end else if (iss.ready) begin
                iss.valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rs_int_issue_select.sv
// Scoreboard bench for rs_int_issue_select with an RS line emulator
// and a spec-level reference model.
module tb_rs_int_issue_select;
    import rs_pkg::*;

    localparam int N  = 4;
    localparam int RW = 5;
    localparam int OW = 8;
    localparam int DW = 32;

    typedef struct packed {
        logic [RW-1:0] rob;
        logic [OW-1:0] opg;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } pkt_t;

    logic clk = 1'b0;
    logic rst, flush, alloc_valid, alloc_ready;
    logic [RW-1:0]   rob_head;
    logic [N-1:0]    line_write_en, line_issue_en;
    logic [N*3-1:0]  line_state;
    logic [N*RW-1:0] line_rob_addr;
    logic [N*OW-1:0] line_opgen;
    logic [N*DW-1:0] line_opnd1, line_opnd2;

    logic [2:0]    st  [N];
    logic [RW-1:0] rob [N];
    logic [OW-1:0] opg [N];
    logic [DW-1:0] o1  [N];
    logic [DW-1:0] o2  [N];
    int            dly [N];
    int            kill[N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            line_state[3*i +: 3]       = st[i];
            line_rob_addr[RW*i +: RW]  = rob[i];
            line_opgen[OW*i +: OW]     = opg[i];
            line_opnd1[DW*i +: DW]     = o1[i];
            line_opnd2[DW*i +: DW]     = o2[i];
        end
    end

    rs_int_issue_select_if #(.ROB_ADDR_W(RW), .OPGEN_W(OW), .DATA_W(DW)) bus();

    rs_int_issue_select #(
        .LINE_NUM(N), .ROB_ADDR_W(RW), .OPGEN_W(OW), .DATA_W(DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .rob_head      (rob_head),
        .alloc_valid   (alloc_valid),
        .alloc_ready   (alloc_ready),
        .line_write_en (line_write_en),
        .line_state    (line_state),
        .line_rob_addr (line_rob_addr),
        .line_opgen    (line_opgen),
        .line_opnd1    (line_opnd1),
        .line_opnd2    (line_opnd2),
        .line_issue_en (line_issue_en),
        .iss           (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    pkt_t sbq[$];
    int unsigned acc_log[$];
    int acc_cyc[$];
    logic [N-1:0] m_mask = '0;
    logic m_valid = 1'b0;
    logic [N-1:0] ex_issue = '0;
    logic [N-1:0] ex_write = '0;
    logic ex_flush = 1'b0;
    bit auto_mode = 1'b0;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Reference model: alloc, oldest-ready pick, packet validity.
    always @(negedge clk) begin
        logic [N-1:0] freev, exp_we, exp_ie;
        int best, bage, age;
        logic cap;
        freev = '0;
        for (int i = 0; i < N; i++) freev[i] = (st[i] == RS_NONE);
        exp_we = '0;
        if (alloc_valid && !flush && !rst) begin
            for (int i = 0; i < N; i++)
                if (freev[i] && exp_we == '0) exp_we[i] = 1'b1;
        end
        best = -1;
        bage = 0;
        for (int i = 0; i < N; i++) begin
            if (st[i] == RS_READY && !m_mask[i]) begin
                age = (int'(rob[i]) - int'(rob_head) + 32) % 32;
                if (best < 0 || age < bage) begin
                    best = i;
                    bage = age;
                end
            end
        end
        cap = (best >= 0) && (!m_valid || bus.ready) && !flush && !rst;
        exp_ie = '0;
        if (cap) exp_ie[best] = 1'b1;
        chk("alloc_ready", 128'(alloc_ready), 128'(|freev));
        chk("write_en", 128'(line_write_en), 128'(exp_we));
        chk("issue_en", 128'(line_issue_en), 128'(exp_ie));
        chk("iss_valid", 128'(bus.valid), 128'(m_valid));
        if (rst || flush) begin
            m_valid = 1'b0;
            m_mask = '0;
            sbq.delete();
        end else begin
            m_mask = exp_ie;
            if (cap) begin
                sbq.push_back({rob[best], opg[best], o1[best], o2[best]});
                m_valid = 1'b1;
            end else if (bus.ready) begin
                m_valid = 1'b0;
            end
        end
        ex_issue = exp_ie;
        ex_write = exp_we;
        ex_flush = flush;
    end

    // Monitor: compare presented packet with scoreboard head.
    always @(negedge clk) begin
        if (!rst && !flush && bus.valid === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pkt: unexpected packet rob=%0h opgen=%0h, none required",
                         bus.rob_addr, bus.opgen);
            end else begin
                chk("pkt", {bus.rob_addr, bus.opgen, bus.opnd1, bus.opnd2},
                    128'(sbq[0]));
                if (bus.ready) begin
                    acc_log.push_back(int'(bus.opgen));
                    acc_cyc.push_back(cyc);
                    void'(sbq.pop_front());
                end
            end
        end
    end

    // RS line emulator: issued lines stay READY one extra cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (ex_flush) begin
                st[i] = RS_NONE;
                kill[i] = 0;
            end else begin
                if (kill[i] > 0) begin
                    kill[i]--;
                    if (kill[i] == 0) st[i] = RS_NONE;
                end
                if (ex_issue[i]) kill[i] = 1;
                if (ex_write[i]) begin
                    st[i] = ($urandom % 8 == 0) ? 3'(5 + $urandom % 3) : RS_WRITE;
                    dly[i] = int'($urandom % 3);
                    rob[i] = rob_head + RW'($urandom_range(0, 15));
                    opg[i] = OW'($urandom);
                    o1[i] = $urandom;
                    o2[i] = $urandom;
                end else if (st[i] == RS_WRITE || st[i] > 3'd4) begin
                    if (dly[i] == 0) st[i] = RS_READY;
                    else dly[i]--;
                end
            end
        end
        if (auto_mode) begin
            alloc_valid = ($urandom % 10) < 6;
            bus.ready = ($urandom % 10) < 7;
            flush = ($urandom % 40) == 0;
            if ($urandom % 8 == 0) rob_head = rob_head + 1'b1;
        end
    endtask

    function automatic bit busy();
        bit b = m_valid;
        for (int i = 0; i < N; i++) if (st[i] == RS_READY) b = 1'b1;
        return b;
    endfunction

    task automatic wait_done(string name);
        int n = 0;
        while (busy() && n < 60) begin
            tick();
            n++;
        end
        chk({name, "_timeout"}, 128'(n >= 60), 128'(0));
    endtask

    function automatic logic [31:0] packlog();
        logic [31:0] v = '0;
        foreach (acc_log[k]) v = (v << 8) | (acc_log[k] & 32'hFF);
        return v;
    endfunction

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        alloc_valid = 1'b0;
        rob_head = '0;
        bus.ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            st[i] = RS_NONE;
            rob[i] = '0;
            opg[i] = '0;
            o1[i] = '0;
            o2[i] = '0;
            dly[i] = 0;
            kill[i] = 0;
        end
        repeat (3) tick();
        chk("rst_valid", 128'(bus.valid), 128'(0));
        chk("rst_rob", 128'(bus.rob_addr), 128'(0));
        rst = 1'b0;
        tick();

        alloc_valid = 1'b1;
        #1;
        chk("first_alloc", 128'(line_write_en), 128'(4'b0001));
        tick();
        alloc_valid = 1'b0;
        wait_done("alloc");

        acc_log.delete();
        acc_cyc.delete();
        rob_head = 5'd30;
        rob[0] = 5'd2;  rob[1] = 5'd31; rob[2] = 5'd30; rob[3] = 5'd5;
        for (int i = 0; i < N; i++) begin
            opg[i] = OW'(i);
            o1[i] = $urandom;
            o2[i] = $urandom;
            st[i] = RS_READY;
        end
        wait_done("age");
        chk("age_order", 128'(packlog()), 128'(32'h02010003));
        chk("b2b", 128'(acc_cyc.size() == 4 ? acc_cyc[3] - acc_cyc[0] : -1), 128'(3));

        acc_log.delete();
        bus.ready = 1'b0;
        opg[1] = 8'h11;
        rob[1] = 5'd9;
        st[1] = RS_READY;
        repeat (5) tick();
        chk("stall_valid", 128'(bus.valid), 128'(1));
        bus.ready = 1'b1;
        wait_done("stall");
        chk("stall_once", 128'(packlog()), 128'(32'h11));

        acc_log.delete();
        bus.ready = 1'b0;
        st[2] = RS_READY;
        opg[2] = 8'h22;
        repeat (2) tick();
        flush = 1'b1;
        bus.ready = 1'b1;
        alloc_valid = 1'b1;
        st[0] = RS_READY;
        #1;
        chk("flush_ie", 128'(line_issue_en), 128'(0));
        chk("flush_we", 128'(line_write_en), 128'(0));
        tick();
        flush = 1'b0;
        alloc_valid = 1'b0;
        chk("flush_drop", 128'(bus.valid), 128'(0));
        wait_done("flush");
        chk("flush_none", 128'(acc_log.size()), 128'(0));

        for (int i = 0; i < N; i++) st[i] = RS_WAIT;
        alloc_valid = 1'b1;
        #1;
        chk("full_ready", 128'(alloc_ready), 128'(0));
        chk("full_we", 128'(line_write_en), 128'(0));
        tick();
        alloc_valid = 1'b0;
        acc_log.delete();
        rob[1] = 5'd7; opg[1] = 8'h01; st[1] = RS_READY;
        rob[3] = 5'd7; opg[3] = 8'h03; st[3] = RS_READY;
        wait_done("tie");
        chk("tie_order", 128'(packlog()), 128'(32'h0103));
        for (int i = 0; i < N; i++) st[i] = RS_NONE;

        auto_mode = 1'b1;
        for (int k = 0; k < 800; k++) begin
            rst = (k == 400 || k == 401);
            tick();
        end
        auto_mode = 1'b0;
        rst = 1'b0;
        flush = 1'b0;
        alloc_valid = 1'b0;
        bus.ready = 1'b1;
        tick();
        wait_done("final");
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
